// File: rtl/inv_mix_columns_seq_pkg.sv
// Purpose : shared constants, FSM state type and GF(2^8) helpers for the
//           sequential AES InvMixColumns block.
// Latency : n/a (package).  Backpressure: n/a.
package inv_mix_columns_seq_pkg;

    // AES field reduction polynomial x^8+x^4+x^3+x+1, with the x^8 term implied.
    localparam logic [7:0] GF_POLY = 8'h1B;

    // InvMixColumns matrix coefficients (first row is E B D 9, later rows rotate it).
    localparam logic [3:0] COEF_E = 4'd14;
    localparam logic [3:0] COEF_B = 4'd11;
    localparam logic [3:0] COEF_D = 4'd13;
    localparam logic [3:0] COEF_9 = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiply by x in GF(2^8).
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    // Multiply by a 4-bit constant.  This is shift-and-add over an xtime chain,
    // so it unrolls to plain XOR logic.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] acc;
        logic [7:0] pow;
        acc = 8'h00;
        pow = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ pow;
            pow = xtime(pow);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_mix_columns_seq_word.sv
// Purpose : InvMixColumns applied to a single 32-bit column, purely combinational.
// Latency : 0 cycles.  Backpressure: none.
// Ports   : col_in  = column, byte r at bits [31-8r -: 8]; col_out = transformed column.
module inv_mix_column_word
    import inv_mix_columns_seq_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign b0 = gf_mul(a0, COEF_E) ^ gf_mul(a1, COEF_B) ^ gf_mul(a2, COEF_D) ^ gf_mul(a3, COEF_9);
    assign b1 = gf_mul(a0, COEF_9) ^ gf_mul(a1, COEF_E) ^ gf_mul(a2, COEF_B) ^ gf_mul(a3, COEF_D);
    assign b2 = gf_mul(a0, COEF_D) ^ gf_mul(a1, COEF_9) ^ gf_mul(a2, COEF_E) ^ gf_mul(a3, COEF_B);
    assign b3 = gf_mul(a0, COEF_B) ^ gf_mul(a1, COEF_D) ^ gf_mul(a2, COEF_9) ^ gf_mul(a3, COEF_E);

    assign col_out = {b0, b1, b2, b3};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Purpose : sequential AES InvMixColumns.  It transforms one column per cycle in an IDLE/CALC/DONE FSM.
// Latency : out_valid rises 4 edges after the accepting edge.  The minimum issue interval is 5 cycles.
// Backpressure: the block holds the result in DONE until out_ready is seen.  in_ready is high only in IDLE.
// Ports   : clk, rst_n (async, active-low); in_valid/in_ready/state_in form the input handshake;
//           out_valid/out_ready/state_out form the output handshake; busy is high when not IDLE.
module inv_mix_columns_seq
    import inv_mix_columns_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    state_t       state, state_nxt;
    logic [1:0]   col_idx;
    logic [127:0] work;
    logic [127:0] result;
    logic [31:0]  col_cur;
    logic [31:0]  col_new;

    // All handshake flags decode from the state register.  Reset therefore reaches them asynchronously.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign state_out = result;

    always_comb begin
        col_cur = work[127:96];
        case (col_idx)
            2'd0:    col_cur = work[127:96];
            2'd1:    col_cur = work[95:64];
            2'd2:    col_cur = work[63:32];
            default: col_cur = work[31:0];
        endcase
    end

    inv_mix_column_word u_col (
        .col_in  (col_cur),
        .col_out (col_new)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)          state_nxt = CALC;
            CALC:    if (col_idx == 2'd3)   state_nxt = DONE;
            DONE:    if (out_ready)         state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // The result register is separate from the working register.  This keeps
    // state_out stable while the next state is being computed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work    <= '0;
            result  <= '0;
            col_idx <= 2'd0;
        end else if (state == IDLE && in_valid) begin
            work    <= state_in;
            col_idx <= 2'd0;
        end else if (state == CALC) begin
            case (col_idx)
                2'd0:    work[127:96] <= col_new;
                2'd1:    work[95:64]  <= col_new;
                2'd2:    work[63:32]  <= col_new;
                default: work[31:0]   <= col_new;
            endcase
            col_idx <= col_idx + 2'd1;
            // The last column goes straight into the result.  Columns 0..2 are already final in work.
            if (col_idx == 2'd3) result <= {work[127:32], col_new};
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
module tb_inv_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] state_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] state_out;
    logic         busy;

    inv_mix_columns_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic [127:0] exp_q[$];
    int           acc_q[$];
    int           assert_cnt = 0;
    int           fail_cnt = 0;

    localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] V2_IO  = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
    localparam logic [127:0] V3_IN  = 128'hc6c6c6c6_01010101_4d7ebdf8_d5d5d7d6;
    localparam logic [127:0] V3_OUT = 128'hc6c6c6c6_01010101_2d26314c_d4d4d4d5;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Forward MixColumns reference, used for the round trip.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    function automatic logic [127:0] mix_state(input logic [127:0] s);
        return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
    endfunction

    // The monitor checks latency on each rising out_valid.  It pops and compares on each output handshake.
    logic prev_vld = 1'b0;
    int   acc_tmp;
    always @(negedge clk) begin
        if (out_valid && !prev_vld) begin
            if (acc_q.size() == 0) check("unexpected out_valid", 128'd1, 128'd0);
            else begin
                acc_tmp = acc_q.pop_front();
                check("latency", 128'(cycle - acc_tmp), 128'd4);
            end
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected output", state_out, 128'd0);
            else check("state_out", state_out, exp_q.pop_front());
        end
        prev_vld = out_valid;
    end

    task automatic send(input logic [127:0] v, input logic [127:0] e);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("in_ready timeout", 128'd0, 128'd1);
            return;
        end
        in_valid = 1'b1;
        state_in = v;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        acc_q.push_back(cycle);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check("drain timeout", 128'(exp_q.size()), 128'd0);
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    logic [127:0] orig;

    initial begin
        // The reset state is checked while rst_n is held low.
        #12;
        check("reset out_valid", 128'(out_valid), 128'd0);
        check("reset in_ready",  128'(in_ready),  128'd1);
        check("reset busy",      128'(busy),      128'd0);
        check("reset state_out", state_out,       128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // The first vector is accepted on the first edge after reset release.
        send(V1_IN, V1_OUT);
        wait_idle();
        send(V2_IO, V2_IO);
        wait_idle();
        send(V3_IN, V3_OUT);
        wait_idle();

        // Backpressure: out_ready is held low in DONE, and in_valid is pulsed and must be ignored.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(V1_IN, V1_OUT);
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        check("bp reached DONE", 128'(out_valid), 128'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp out_valid", 128'(out_valid), 128'd1);
            check("bp state_out", state_out, V1_OUT);
            check("bp in_ready",  128'(in_ready), 128'd0);
            if (i == 2) begin
                in_valid = 1'b1;
                state_in = V2_IO;
            end
            if (i == 5) in_valid = 1'b0;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post handoff out_valid", 128'(out_valid), 128'd0);
        check("post handoff in_ready",  128'(in_ready),  128'd1);
        check("post handoff state_out", state_out,       V1_OUT);
        wait_idle();

        // Reset is applied after column 1 is written, which discards the in-flight state.
        send(V3_IN, V3_OUT);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 128'(out_valid), 128'd0);
        check("midreset state_out", state_out,       128'd0);
        check("midreset in_ready",  128'(in_ready),  128'd1);
        check("midreset busy",      128'(busy),      128'd0);
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        send(V1_IN, V1_OUT);
        wait_idle();

        // Round trip: each random state is mixed forward by the model, then inverted by the DUT.
        for (int n = 0; n < 100; n++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            send(mix_state(orig), orig);
        end
        wait_idle();
        check("latency queue drained", 128'(acc_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/inv_mix_columns_seq.md
INV_MIX_COLUMNS_SEQ -- requirements
Module: inv_mix_columns_seq

Interface
REQ-001 Parameters: none; width fixed at 128-bit AES state.
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  state_in holds a state to transform.
REQ-005 in_ready  output  1  block can accept a state.
REQ-006 state_in  input  128  AES state, column-major; column c = bits [127-32c -: 32]; byte r of a column = bits [31-8r -: 8] of that column.
REQ-007 out_valid  output  1  state_out holds a finished result.
REQ-008 out_ready  input  1  consumer accepts state_out.
REQ-009 state_out  output  128  InvMixColumns(state_in), same byte layout.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge with in_valid && in_ready.
REQ-013 On transfer, the block SHALL register state_in, clear the 2-bit column counter to 0, and enter CALC.
REQ-014 In CALC, each cycle SHALL transform exactly one column (index = counter): b0=14a0^11a1^13a2^9a3, b1=9a0^14a1^11a2^13a3, b2=13a0^9a1^14a2^11a3, b3=11a0^13a1^9a2^14a3; GF(2^8) arithmetic, polynomial 0x11B.
REQ-015 The transformed column SHALL overwrite its slot in the working register; the counter SHALL increment modulo 4.
REQ-016 After column 3 is written, the FSM SHALL enter DONE; out_valid SHALL be 1 exactly 4 edges after the accepting edge.
REQ-017 In DONE, out_valid SHALL stay 1 and state_out SHALL stay stable until out_valid && out_ready.
REQ-018 On the output transfer edge, the FSM SHALL return to IDLE; out_valid SHALL drop and in_ready SHALL rise in the next cycle. Back-to-back input and output in the same cycle is not supported; minimum issue interval is 5 cycles.
REQ-019 in_valid asserted while not in IDLE SHALL be ignored, with no effect on the in-flight state.
REQ-020 state_out SHALL hold the last result after the handoff, until the next result overwrites it.
REQ-021 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-022 When rst_n is low, the block SHALL immediately, independent of clk: set FSM to IDLE, counter to 0, out_valid 0, busy 0, in_ready 1, state_out 0, working register 0.
REQ-023 Reset asserted during CALC or DONE SHALL discard the in-flight state; no partial result may appear.
REQ-024 After rst_n deasserts, the block SHALL accept input on the first rising edge.

Structure
REQ-025 A shared package SHALL hold the reduction polynomial constant 8'h1B, the FSM state enum, and the InvMixColumns coefficient constants 14/11/13/9.
REQ-026 The column transform SHALL be one combinational sub-module, inv_mix_column_word (32-bit in/out), built from xtime chains and XOR (GF addition).

Verification
REQ-027 Single column: state_in = 8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> state_out = db135345_f20a225c_01010101_d4d4d4d5; out_valid at accept edge +4.
REQ-028 Identity/fixed point: state_in = c6c6c6c6 repeated 4 times -> same value out; also 4d7ebdf8 in column 2 -> 2d26314c in column 2.
REQ-029 Backpressure: out_ready held low 10 cycles in DONE -> out_valid and state_out stable, in_ready 0, a new in_valid is ignored; out_ready=1 -> IDLE next cycle.
REQ-030 Reset mid-CALC: rst_n low after column 1 -> out_valid 0, state_out 0 immediately; next vector gives the correct result.
REQ-031 Round trip: 100 random states through a MixColumns reference model, then this block -> original state, with error_count 0 reported at the end.
